// File: rtl/synch_pkg.sv
// Packet-type codes and the response-queue entry shared by the synchronization register bank.
package synch_pkg;

    localparam logic [2:0] PKT_READ      = 3'b100;
    localparam logic [2:0] PKT_WRITE     = 3'b010;
    localparam logic [2:0] PKT_FADD      = 3'b111;
    localparam logic [2:0] PKT_CAS       = 3'b011;
    localparam logic [2:0] PKT_RESP_DATA = 3'b110;
    localparam logic [2:0] PKT_RESP_ACK  = 3'b101;

    // Fields are sized for the widest legal configuration; the top narrows them on the way out.
    localparam int ENTRY_ADDR_W = 64;
    localparam int ENTRY_ID_W   = 16;
    localparam int ENTRY_VAL_W  = 64;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [ENTRY_ID_W-1:0]   id;
        logic [2:0]              pkt_type;
        logic [ENTRY_VAL_W-1:0]  value;
    } resp_entry_t;

endpackage

// File: rtl/synch_resp_fifo.sv
// Synchronous response FIFO with occupancy count; pops whenever the consumer is ready and data is present.
module synch_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop_ready,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   pop
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign pop     = pop_ready && !empty;
    assign do_push = push && !full;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/synch_reg_bank.sv
// Atomic synchronization register bank with valid/ready requests and a buffered response queue.
// Define SYNCH_REG_CAS_EN to enable compare-and-swap packets (3'b011).
module synch_reg_bank
    import synch_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 36,
    parameter int ID_W       = 4,
    parameter int ADD_W      = 15,
    parameter int PKT_W      = 512,
    parameter int RESP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ID_W-1:0]   req_id,
    input  logic [2:0]        req_type,
    input  logic [PKT_W-1:0]  req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [ID_W-1:0]   resp_id,
    output logic [2:0]        resp_type,
    output logic [PKT_W-1:0]  resp_data
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(RESP_DEPTH) + 1;

    function automatic logic [DATA_W-1:0] fadd_wrap(input logic [DATA_W-1:0] r,
                                                    input logic signed [ADD_W-1:0] inc);
        return r + {{(DATA_W-ADD_W){inc[ADD_W-1]}}, inc};
    endfunction

    logic [DATA_W-1:0]        regs [NUM_REGS];
    logic                     accept;
    logic [IDX_W-1:0]         idx;
    logic [DATA_W-1:0]        cur;
    logic [DATA_W-1:0]        wr_val;
    logic signed [ADD_W-1:0]  inc;
`ifdef SYNCH_REG_CAS_EN
    logic [DATA_W-1:0]        cmp_val;
    logic [DATA_W-1:0]        swap_val;
`endif

    logic                     upd_en;
    logic [DATA_W-1:0]        upd_val;
    logic                     push_en;
    logic [2:0]               push_type;
    logic [DATA_W-1:0]        push_val;

    resp_entry_t              push_entry;
    resp_entry_t              head_entry;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic                     unused_ok;

    // Only the registered occupancy gates acceptance, so resp_ready never reaches req_ready.
    assign req_ready = rst && !fifo_full;
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[IDX_W+1:2];
    assign cur       = regs[idx];
    assign wr_val    = req_data[DATA_W-1:0];
    assign inc       = req_data[32+ADD_W-1:32];
`ifdef SYNCH_REG_CAS_EN
    assign cmp_val   = req_data[DATA_W-1:0];
    assign swap_val  = req_data[DATA_W+31:32];
`endif

    always_comb begin
        upd_en    = 1'b0;
        upd_val   = cur;
        push_en   = 1'b0;
        push_type = PKT_RESP_DATA;
        push_val  = cur;
        if (accept) begin
            case (req_type)
                PKT_READ: begin
                    push_en = 1'b1;
                end
                PKT_WRITE: begin
                    upd_en    = 1'b1;
                    upd_val   = wr_val;
                    push_en   = 1'b1;
                    push_type = PKT_RESP_ACK;
                    push_val  = '0;
                end
                PKT_FADD: begin
                    upd_en  = 1'b1;
                    upd_val = fadd_wrap(cur, inc);
                    push_en = 1'b1;
                end
`ifdef SYNCH_REG_CAS_EN
                PKT_CAS: begin
                    upd_en  = (cur == cmp_val);
                    upd_val = swap_val;
                    push_en = 1'b1;
                end
`endif
                default: begin
                    push_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (upd_en) begin
            regs[idx] <= upd_val;
        end
    end

    always_comb begin
        push_entry          = '0;
        push_entry.addr     = 64'(req_addr);
        push_entry.id       = 16'(req_id);
        push_entry.pkt_type = push_type;
        push_entry.value    = 64'(push_val);
    end

    synch_resp_fifo #(
        .WIDTH ($bits(resp_entry_t)),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_en),
        .push_data (push_entry),
        .pop_ready (resp_ready),
        .head      (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .pop       (fifo_pop)
    );

    // The head slot is driven straight from storage, so it holds still until popped; blank it when empty.
    assign resp_valid = !fifo_empty;
    assign resp_addr  = fifo_empty ? '0 : head_entry.addr[ADDR_W-1:0];
    assign resp_id    = fifo_empty ? '0 : head_entry.id[ID_W-1:0];
    assign resp_type  = fifo_empty ? '0 : head_entry.pkt_type;
    assign resp_data  = fifo_empty ? '0 : PKT_W'(head_entry.value[DATA_W-1:0]);

    assign unused_ok = ^{req_data, req_addr, head_entry, fifo_count, fifo_pop};

endmodule

// File: doc/synch_reg_bank.md
Name: synch_reg_bank

Overview:
Parametrised successor to the single-cycle synchronization register block. It holds NUM_REGS atomic registers, each DATA_W bits wide, and serves read, write, fetch-and-add and (optionally) compare-and-swap packets from the circular-memory interface. It adds a valid/ready request handshake and a buffered response queue, so downstream backpressure no longer drops results. It sits between the request ring and the circular-memory response path.

Parameters:
NUM_REGS, 16, number of synchronization registers (power of 2, >=2)
DATA_W, 32, register width (>= ADD_W+1, <= 64)
ADDR_W, 36, request address width
ID_W, 4, requester id width
ADD_W, 15, width of signed fetch-and-add increment
PKT_W, 512, packet data width
RESP_DEPTH, 4, response FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_addr  in  ADDR_W  byte address; register index = req_addr[IDX_W+1:2], IDX_W=$clog2(NUM_REGS)
req_id  in  ID_W  requester id
req_type  in  3  packet type
req_data  in  PKT_W  operands
resp_valid  out  1  response present
resp_ready  in  1  downstream accepts response
resp_addr  out  ADDR_W  echoed req_addr
resp_id  out  ID_W  echoed req_id
resp_type  out  3  response packet type
resp_data  out  PKT_W  result in [DATA_W-1:0], upper bits zero

Behaviour:
- Reset (rst==0 at posedge): all registers 0; FIFO empty; resp_valid=0; resp_addr/id/type/data=0; req_ready=0 during reset.
- req_ready = rst && (fifo_count < RESP_DEPTH); registered-count only, no combinational path from resp_ready.
- Accept = req_valid && req_ready. All register updates and the FIFO push happen on the accept edge.
- Ops, where R = reg[idx] before the edge:
  - 3'b100 read: no update; push {type 3'b110, data R}.
  - 3'b010 write: R <= req_data[DATA_W-1:0]; push {3'b101, data 0}.
  - 3'b111 fetch-add: R <= R + sext(req_data[32+ADD_W-1:32]) mod 2^DATA_W; push {3'b110, old R}.
  - 3'b011 CAS (feature): if R == req_data[DATA_W-1:0] then R <= req_data[DATA_W+31:32]; push {3'b110, old R}.
  - Any other type: consumed, no update, no push.
- Address and id are echoed unchanged. Address bits above IDX_W+1 and bits [1:0] are ignored.
- Latency: a response is visible on resp_valid on the cycle after the accept edge when the FIFO was empty. Order is strictly FIFO.
- Back-to-back operations to the same register each see the previous op's result; there are no hazard stalls.
- Full FIFO: req_ready=0 even if a pop occurs that cycle; it rises the cycle after the pop.
- Simultaneous push and pop: count unchanged, pointers wrap modulo RESP_DEPTH.
- resp_* outputs hold stable while resp_valid && !resp_ready.
- Reset asserted mid-stream discards queued responses and clears the registers.

Optional Feature:
SYNCH_REG_CAS_EN
- Defined: 3'b011 performs compare-and-swap as described above.
- Undefined: 3'b011 is treated as an unknown type (consumed, no update, no response). No CAS comparator is synthesized.

Decomposition:
- Package synch_pkg: packet-type localparams (PKT_READ=3'b100, PKT_WRITE=3'b010, PKT_FADD=3'b111, PKT_CAS=3'b011, PKT_RESP_DATA=3'b110, PKT_RESP_ACK=3'b101) and a resp_entry_t struct {addr, id, type, value}.
- Sub-module synch_resp_fifo: parametrised synchronous FIFO with count, full, empty and pop-on-ready. Register array and op decode stay in the top module.

Test Plan:
- Reset, then read reg 3 (addr 0x0C, id 5) -> resp next cycle {type 3'b110, data 0, addr 0x0C, id 5}.
- Write 0xDEADBEEF to reg 2, then fetch-add with data[46:32]=15'h7FFF (-1) -> ack 3'b101 with data 0; fetch-add returns 0xDEADBEEF; subsequent read returns 0xDEADBEEE.
- Fetch-add +1 on 0xFFFFFFFF -> returns 0xFFFFFFFF, register wraps to 0.
- CAS on reg 1 holding 7: compare 7/swap 9 -> returns 7, reg=9; compare 7/swap 1 -> returns 9, reg stays 9. With macro undefined -> no response, reg unchanged.
- Hold resp_ready=0, issue 5 reads -> 4 accepted, req_ready=0, resp_* stable; release -> drained in order, req_ready=1 one cycle after first pop.
- Unknown type 3'b000 between two reads -> exactly two responses, in order.
- rst low with 3 queued responses -> resp_valid=0 next cycle, all registers read back 0.
